// File: rtl/bht_rq_pkg.sv
// Shared types and helpers for the BHT resolve queue.
// Entry/update PC fields are sized for the widest supported PC.
package bht_rq_pkg;

  localparam int RQ_PC_W = 64;

  typedef struct packed {
    logic [RQ_PC_W-1:0] pc;
    logic               pred_taken;
  } rq_entry_t;

  typedef struct packed {
    logic               valid;
    logic [RQ_PC_W-1:0] pc;
    logic               taken;
    logic               mispredict;
  } bht_upd_t;

  function automatic logic [31:0] sat_inc32(
    input logic [31:0] v,
    input logic        en
  );
    if (en && (v != 32'hFFFF_FFFF))
      return v + 32'd1;
    return v;
  endfunction

endpackage

// File: rtl/bht_resolve_queue_fifo.sv
// In-order prediction record storage: head/tail/count ring buffer.
// Flush and reset both empty it; entry contents are never reset.
module rq_fifo
  import bht_rq_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          flush_i,
  input  logic          push_i,
  input  rq_entry_t     push_data_i,
  input  logic          pop_i,
  output rq_entry_t     head_o,
  output logic [CW-1:0] count_o,
  output logic          full_o,
  output logic          empty_o
);

  localparam int PW = $clog2(DEPTH);

  rq_entry_t         r_mem [DEPTH];
  logic [PW-1:0]     r_head;
  logic [PW-1:0]     r_tail;
  logic [CW-1:0]     r_count;

  logic              w_push;
  logic              w_pop;

  assign full_o  = (r_count == CW'(DEPTH));
  assign empty_o = (r_count == '0);
  assign count_o = r_count;
  assign head_o  = r_mem[r_head];

  assign w_push = push_i & ~full_o & ~flush_i;
  assign w_pop  = pop_i & ~empty_o & ~flush_i;

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push)
        r_tail <= r_tail + 1'b1;
      if (w_pop)
        r_head <= r_head + 1'b1;
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i && w_push)
      r_mem[r_tail] <= push_data_i;
  end

endmodule

// File: rtl/bht_resolve_queue.sv
// Pairs in-order branch resolutions with recorded BHT predictions and
// emits a registered training update plus mispredict statistics.
module bht_resolve_queue
  import bht_rq_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int VLEN  = 64
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     flush_i,
  input  logic                     push_valid_i,
  output logic                     push_ready_o,
  input  logic [VLEN-1:0]          push_pc_i,
  input  logic                     push_pred_taken_i,
  input  logic                     resolve_valid_i,
  input  logic                     resolve_taken_i,
  output logic                     bht_update_valid_o,
  output logic [VLEN-1:0]          bht_update_pc_o,
  output logic                     bht_update_taken_o,
  output logic                     mispredict_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic [31:0]              resolved_cnt_o,
  output logic [31:0]              mispredict_cnt_o,
  output logic                     resolve_err_o
);

  localparam int CW = $clog2(DEPTH) + 1;

  rq_entry_t       w_push_entry;
  rq_entry_t       w_head;
  logic            w_full;
  logic            w_empty;
  logic [CW-1:0]   w_count;
  logic            w_push_acc;
  logic            w_res_acc;
  logic            w_res_err;
  logic            w_mis;

  bht_upd_t        r_upd;
  logic [31:0]     r_res_cnt;
  logic [31:0]     r_mis_cnt;
  logic            r_err;

  always_comb begin
    w_push_entry            = '0;
    w_push_entry.pc         = RQ_PC_W'(push_pc_i);
    w_push_entry.pred_taken = push_pred_taken_i;
  end

  // Ready comes from registered count only; a same-cycle pop never frees a slot.
  assign push_ready_o = ~w_full;
  assign w_push_acc   = push_valid_i & push_ready_o & ~flush_i;
  assign w_res_acc    = resolve_valid_i & ~w_empty & ~flush_i;
  assign w_res_err    = resolve_valid_i & w_empty & ~flush_i;
  assign w_mis        = w_head.pred_taken ^ resolve_taken_i;

  rq_fifo #(
    .DEPTH (DEPTH),
    .CW    (CW)
  ) u_fifo (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .flush_i     (flush_i),
    .push_i      (w_push_acc),
    .push_data_i (w_push_entry),
    .pop_i       (w_res_acc),
    .head_o      (w_head),
    .count_o     (w_count),
    .full_o      (w_full),
    .empty_o     (w_empty)
  );

  // Payload holds between pulses so the BHT may sample it lazily.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_upd <= '0;
    end else begin
      r_upd.valid <= w_res_acc;
      if (w_res_acc) begin
        r_upd.pc         <= w_head.pc;
        r_upd.taken      <= resolve_taken_i;
        r_upd.mispredict <= w_mis;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_res_cnt <= '0;
      r_mis_cnt <= '0;
      r_err     <= 1'b0;
    end else begin
      r_res_cnt <= sat_inc32(r_res_cnt, w_res_acc);
      r_mis_cnt <= sat_inc32(r_mis_cnt, w_res_acc & w_mis);
      if (w_res_err)
        r_err <= 1'b1;
    end
  end

  assign bht_update_valid_o = r_upd.valid;
  assign bht_update_pc_o    = r_upd.pc[VLEN-1:0];
  assign bht_update_taken_o = r_upd.taken;
  assign mispredict_o       = r_upd.mispredict;
  assign count_o            = w_count;
  assign resolved_cnt_o     = r_res_cnt;
  assign mispredict_cnt_o   = r_mis_cnt;
  assign resolve_err_o      = r_err;

endmodule

// File: tb/tb_bht_resolve_queue.sv
// Scoreboard bench for bht_resolve_queue against a queue-based model.
// Stimulus feeds the model at each edge; a negedge monitor checks outputs.
module tb_bht_resolve_queue;

  localparam int DEPTH = 8;
  localparam int VLEN  = 64;

  logic            clk_i = 1'b0;
  logic            rst_i = 1'b1;
  logic            flush_i = 1'b0;
  logic            push_valid_i = 1'b0;
  logic            push_ready_o;
  logic [VLEN-1:0] push_pc_i = '0;
  logic            push_pred_taken_i = 1'b0;
  logic            resolve_valid_i = 1'b0;
  logic            resolve_taken_i = 1'b0;
  logic            bht_update_valid_o;
  logic [VLEN-1:0] bht_update_pc_o;
  logic            bht_update_taken_o;
  logic            mispredict_o;
  logic [3:0]      count_o;
  logic [31:0]     resolved_cnt_o;
  logic [31:0]     mispredict_cnt_o;
  logic            resolve_err_o;

  always #5 clk_i = ~clk_i;

  bht_resolve_queue #(.DEPTH(DEPTH), .VLEN(VLEN)) dut (
    .clk_i              (clk_i),
    .rst_i              (rst_i),
    .flush_i            (flush_i),
    .push_valid_i       (push_valid_i),
    .push_ready_o       (push_ready_o),
    .push_pc_i          (push_pc_i),
    .push_pred_taken_i  (push_pred_taken_i),
    .resolve_valid_i    (resolve_valid_i),
    .resolve_taken_i    (resolve_taken_i),
    .bht_update_valid_o (bht_update_valid_o),
    .bht_update_pc_o    (bht_update_pc_o),
    .bht_update_taken_o (bht_update_taken_o),
    .mispredict_o       (mispredict_o),
    .count_o            (count_o),
    .resolved_cnt_o     (resolved_cnt_o),
    .mispredict_cnt_o   (mispredict_cnt_o),
    .resolve_err_o      (resolve_err_o)
  );

  typedef struct {
    logic [63:0] pc;
    bit          pred;
  } m_ent_t;

  typedef struct {
    int          cyc;
    logic [63:0] pc;
    bit          taken;
    bit          mis;
  } sb_t;

  m_ent_t      mq[$];
  sb_t         sb[$];
  int          cyc = 0;
  int          n_chk = 0;
  int          n_fail = 0;
  bit          mon_en = 0;
  logic [31:0] m_res = '0;
  logic [31:0] m_mis = '0;
  bit          m_err = 0;
  logic [63:0] m_lpc = '0;
  bit          m_lt = 0;
  bit          m_lm = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] sat(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  task automatic model_edge(input bit pv, input logic [63:0] pc, input bit pt,
                            input bit rv, input bit rt, input bit fl);
    int     sz;
    m_ent_t e;
    bit     mis;
    cyc++;
    if (fl) begin
      mq.delete();
      return;
    end
    sz = mq.size();
    if (rv && sz == 0)
      m_err = 1;
    if (rv && sz > 0) begin
      e   = mq.pop_front();
      mis = (e.pred != rt);
      sb.push_back('{cyc, e.pc, rt, mis});
      m_lpc = e.pc;
      m_lt  = rt;
      m_lm  = mis;
      m_res = sat(m_res);
      if (mis)
        m_mis = sat(m_mis);
    end
    if (pv && sz < DEPTH)
      mq.push_back('{pc, pt});
  endtask

  task automatic step(input bit pv, input logic [63:0] pc, input bit pt,
                      input bit rv, input bit rt, input bit fl);
    push_valid_i      = pv;
    push_pc_i         = pc;
    push_pred_taken_i = pt;
    resolve_valid_i   = rv;
    resolve_taken_i   = rt;
    flush_i           = fl;
    @(posedge clk_i);
    model_edge(pv, pc, pt, rv, rt, fl);
    #1;
    push_valid_i    = 0;
    resolve_valid_i = 0;
    flush_i         = 0;
  endtask

  task automatic push(input logic [63:0] pc, input bit pt);
    step(1, pc, pt, 0, 0, 0);
  endtask

  task automatic resolve(input bit rt);
    step(0, 0, 0, 1, rt, 0);
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    rst_i = 1;
    @(posedge clk_i);
    cyc++;
    mq.delete();
    sb.delete();
    m_res = '0; m_mis = '0; m_err = 0;
    m_lpc = '0; m_lt = 0; m_lm = 0;
    #1;
    rst_i = 0;
  endtask

  sb_t s;
  bit  ev;

  always @(negedge clk_i) begin
    if (mon_en) begin
      ev = (sb.size() > 0) && (sb[0].cyc == cyc);
      chk("upd_valid", {63'd0, bht_update_valid_o}, {63'd0, ev});
      if (ev) begin
        s = sb.pop_front();
        chk("sb_pc", bht_update_pc_o, s.pc);
        chk("sb_taken", {63'd0, bht_update_taken_o}, {63'd0, s.taken});
        chk("sb_mis", {63'd0, mispredict_o}, {63'd0, s.mis});
      end else begin
        chk("hold_pc", bht_update_pc_o, m_lpc);
        chk("hold_taken", {63'd0, bht_update_taken_o}, {63'd0, m_lt});
        chk("hold_mis", {63'd0, mispredict_o}, {63'd0, m_lm});
      end
      chk("count", {60'd0, count_o}, 64'(mq.size()));
      chk("ready", {63'd0, push_ready_o}, {63'd0, (mq.size() < DEPTH)});
      chk("res_cnt", {32'd0, resolved_cnt_o}, {32'd0, m_res});
      chk("mis_cnt", {32'd0, mispredict_cnt_o}, {32'd0, m_mis});
      chk("err", {63'd0, resolve_err_o}, {63'd0, m_err});
    end
  end

  initial begin
    do_reset();
    mon_en = 1;
    idle();

    push(64'h100, 1); push(64'h104, 0); push(64'h108, 1);
    resolve(1);
    chk("t1_u0_pc", bht_update_pc_o, 64'h100);
    chk("t1_u0_mis", {63'd0, mispredict_o}, 64'd0);
    resolve(1);
    chk("t1_u1_pc", bht_update_pc_o, 64'h104);
    chk("t1_u1_mis", {63'd0, mispredict_o}, 64'd1);
    resolve(1);
    chk("t1_u2_mis", {63'd0, mispredict_o}, 64'd0);
    idle();
    chk("t1_mis_cnt", {32'd0, mispredict_cnt_o}, 64'd1);
    chk("t1_res_cnt", {32'd0, resolved_cnt_o}, 64'd3);

    for (int i = 0; i < 8; i++) push(64'h1000 + 64'(i * 4), i[0]);
    chk("t2_count_full", {60'd0, count_o}, 64'd8);
    chk("t2_ready_full", {63'd0, push_ready_o}, 64'd0);
    step(1, 64'hDEAD, 1, 1, 1, 0);
    chk("t2_count_7", {60'd0, count_o}, 64'd7);
    for (int i = 0; i < 7; i++) resolve(i[0]);
    chk("t2_drained", {60'd0, count_o}, 64'd0);

    do_reset();
    resolve(1);
    chk("t3_err", {63'd0, resolve_err_o}, 64'd1);
    idle(); idle();
    chk("t3_err_held", {63'd0, resolve_err_o}, 64'd1);
    push(64'h300, 0);
    resolve(1);
    chk("t3_pair_pc", bht_update_pc_o, 64'h300);
    chk("t3_pair_mis", {63'd0, mispredict_o}, 64'd1);
    step(1, 64'h340, 1, 1, 0, 0);
    chk("t3_empty_pair_count", {60'd0, count_o}, 64'd1);
    resolve(1);

    for (int i = 0; i < 5; i++) push(64'h500 + 64'(i), 1);
    step(1, 64'h5FF, 0, 1, 1, 1);
    chk("t4_flush_count", {60'd0, count_o}, 64'd0);
    chk("t4_flush_noupd", {63'd0, bht_update_valid_o}, 64'd0);
    push(64'h200, 1);
    resolve(1);
    chk("t4_upd_pc", bht_update_pc_o, 64'h200);
    chk("t4_upd_valid", {63'd0, bht_update_valid_o}, 64'd1);

    push(64'h7000, 1);
    for (int i = 0; i < 20; i++)
      step(1, {32'd0, $urandom}, 1'($urandom), 1, 1'($urandom), 0);
    resolve(1);
    chk("t5_count_zero", {60'd0, count_o}, 64'd0);

    for (int i = 0; i < 400; i++)
      step(1'($urandom_range(0, 2) != 0), {$urandom, $urandom},
           1'($urandom), 1'($urandom_range(0, 2) != 0), 1'($urandom),
           ($urandom_range(0, 40) == 0));
    for (int i = 0; i < DEPTH + 1; i++) resolve(1'($urandom));

    push(64'h900, 1); push(64'h904, 1); push(64'h908, 0);
    #1 force dut.r_res_cnt = 32'hFFFF_FFFE;
    m_res = 32'hFFFF_FFFE;
    #1 release dut.r_res_cnt;
    resolve(1); resolve(1); resolve(1);
    chk("t6_sat", {32'd0, resolved_cnt_o}, 64'hFFFF_FFFF);
    push(64'hA00, 1); push(64'hA04, 0);
    step(1, 64'hA08, 1, 1, 0, 0);
    do_reset();
    chk("t6_rst_count", {60'd0, count_o}, 64'd0);
    chk("t6_rst_valid", {63'd0, bht_update_valid_o}, 64'd0);
    chk("t6_rst_pc", bht_update_pc_o, 64'd0);
    chk("t6_rst_res", {32'd0, resolved_cnt_o}, 64'd0);
    chk("t6_rst_mis", {32'd0, mispredict_cnt_o}, 64'd0);
    idle(); idle();

    mon_en = 0;
    if (sb.size() != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL sb_leftover: got %0d pending expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
